pcu_restore: RTL and testbench
==============================

# pcu_restore

Power restore unit: the restore-side counterpart of the power control unit's backup path. On power-up it drains the backup buffer entry by entry, decodes each `{value, wrapper address}` word and writes the value back into the addressed IC register wrapper via a one-hot restore enable. It sits between the backup buffer's pop port and the K IC register wrappers' restore ports, and signals completion to the system controller.

## Interface
- `K`, 10, number of IC register wrappers; `LOG2_K = $clog2(K)` is derived.
- `N`, 32, data width of one wrapper.
- `DEPTH`, 16, backup buffer depth; `C = $clog2(DEPTH+1)` is the width of `Restored_Cnt`.
- `Clk`  in  1  single clock.
- `Rst`  in  1  synchronous, active-high reset.
- `Pwr_off`  in  1  power-off indication; acts as a synchronous abort.
- `Start_Restore`  in  1  level request to start a restore pass.
- `IsEmpty_Buffer`  in  1  backup buffer empty flag.
- `PopVal_Buffer`  in  N+LOG2_K  head entry; `[N+LOG2_K-1:LOG2_K]` is data, `[LOG2_K-1:0]` is the wrapper address. The buffer is first-word-fall-through, so this is valid whenever `!IsEmpty_Buffer`.
- `PopEn_Buffer`  out  1  pop strobe; the buffer advances on the clock edge where this is high.
- `Clr_Buffer`  out  1  one-cycle buffer clear pulse at the end of a pass.
- `Restore_Ens_IC_Reg_Wrapper`  out  K  one-hot restore write enables.
- `Restore_Vin_IC_Reg_Wrapper`  out  N  restore data, shared by all wrappers.
- `Busy`  out  1  pass in progress.
- `Done`  out  1  pass complete.
- `Err`  out  1  sticky out-of-range address flag (only with the macro).
- `Restored_Cnt`  out  C  number of entries written in the current pass; saturates at `DEPTH`.

## Operation
- FSM states are IDLE, POP, WRITE, CLEAR, DONE.
- **IDLE:** waits for `Start_Restore`.
  - `Start_Restore` with `IsEmpty_Buffer` → CLEAR.
  - `Start_Restore` without `IsEmpty_Buffer` → POP.
  - On leaving IDLE: clear `Restored_Cnt` and `Err`.
- **POP:**
  - Assert `PopEn_Buffer` for exactly one cycle.
  - Latch `PopVal_Buffer` into the hold register (data and address).
  - → WRITE.
- **WRITE:**
  - Drive `Restore_Ens_IC_Reg_Wrapper` = one-hot(hold address) and `Restore_Vin_IC_Reg_Wrapper` = hold data for one cycle.
  - Increment `Restored_Cnt` (saturating).
  - Next state: `IsEmpty_Buffer` → CLEAR, otherwise → POP.
- **CLEAR:** `Clr_Buffer` = 1 for one cycle → DONE.
- **DONE:**
  - `Done` = 1 and stays high while `Start_Restore` stays high.
  - `Start_Restore` low → IDLE.
- **Outputs by state:**
  - `Busy` = 1 in POP, WRITE and CLEAR.
  - Enables, `PopEn_Buffer` and `Clr_Buffer` are 0 in every state not listed above.
- **Duplicate addresses:** each entry is written in pop order, so the last entry for an address wins.
- **`Rst` or `Pwr_off`, from any state:**
  - Next state is IDLE.
  - Hold register, `Restored_Cnt` and `Err` clear to 0.
  - No further pop or enable is issued.
  - `Rst` takes priority over all other inputs.
- **Reset values:** every output is 0.

## Timing
- Start is sampled at edge 0.
  - Non-empty buffer: POP during cycle 1, first enable during cycle 2.
  - Throughput: one entry per 2 cycles.
- Empty buffer: CLEAR during cycle 1, `Done` from cycle 2.
- `IsEmpty_Buffer` is sampled in WRITE. A buffer that goes empty at the WRITE edge gives CLEAR in the next cycle.
- Restore data and enables are registered outputs, aligned in the same cycle.
- `PopEn_Buffer` is never asserted while `IsEmpty_Buffer` is high.

## Configuration
- Macro: `PCU_RESTORE_ADDR_CHECK_EN`.
- **Defined:**
  - A hold address ≥ K makes WRITE drive all enables 0.
  - `Restored_Cnt` is not incremented for that entry.
  - `Err` is set (sticky until the next pass, `Rst` or `Pwr_off`).
  - The pass continues.
- **Undefined:**
  - No comparison logic is built; the address is decoded directly.
  - An out-of-range address produces no enable, but `Restored_Cnt` still increments.
  - `Err` is tied to 0.

## Structure
- **Shared package:**
  - FSM state enum (`ST_IDLE`, `ST_POP`, `ST_WRITE`, `ST_CLEAR`, `ST_DONE`).
  - Entry field slicing constants (`ADDR_LSB`, `DATA_LSB`), shared with the backup side.
- **Sub-module:** `pcu_restore_fsm` (next-state and output decode).
  - The datapath (hold register, decoder, counter) stays in the top module.

## Test plan
All scenarios use K=10, N=32.
- **Empty buffer:** `Start_Restore`=1 with `IsEmpty_Buffer`=1 → `Clr_Buffer` pulses in cycle 1, `Done`=1 from cycle 2, enables stay 0, `Restored_Cnt`=0.
- **Three entries:** buffer holds {0xDEADBEEF, 3}, {0x12345678, 0}, {0xA5A5A5A5, 9}.
  - Enables 0x008, 0x001, 0x200 with the matching data in cycles 2, 4 and 6.
  - `Clr_Buffer` in cycle 7, `Restored_Cnt`=3.
- **Out-of-range address (macro defined):** entry {0xCAFEF00D, 12} followed by {0x1, 2}.
  - No enable for the first entry; `Err`=1.
  - Enable 0x004 for the second entry; `Restored_Cnt`=1.
- **`Pwr_off` abort:** `Pwr_off`=1 during the second POP of a 3-entry pass → IDLE next cycle, no further `PopEn_Buffer` or enable pulses, `Restored_Cnt`=0.
- **Restart:** hold `Start_Restore` through DONE, then drop it for 1 cycle and reassert.
  - `Done` drops; a new pass starts with `Restored_Cnt` cleared.
- **`Rst` mid-write:** `Rst`=1 during WRITE → all outputs 0 on the next cycle, state IDLE.

Source files
------------

// File: rtl/pcu_restore_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module      : pcu_restore_pkg
// Description : Shared constants for the power restore unit: FSM state
//               encoding and backup-entry field positions. The field layout
//               is shared with the backup side of the power control unit.
// Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
package pcu_restore_pkg;

   // FSM state encoding
   localparam int         STATE_W  = 3;
   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_POP   = 3'd1;
   localparam logic [2:0] ST_WRITE = 3'd2;
   localparam logic [2:0] ST_CLEAR = 3'd3;
   localparam logic [2:0] ST_DONE  = 3'd4;

   // Entry layout {data, wrapper address}: the address sits in the low bits
   localparam int ADDR_LSB = 0;
   // Data LSB for the default wrapper count of 10
   localparam int DATA_LSB = ADDR_LSB + $clog2(10);

   // Data LSB for an arbitrary address width
   function automatic int data_lsb(input int log2_k);
      return ADDR_LSB + log2_k;
   endfunction

endpackage
`default_nettype wire

// File: rtl/pcu_restore_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module      : pcu_restore_if
// Description : Bus bundle between the restore unit, the backup buffer pop
//               port and the IC register wrapper restore ports.
// Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
interface pcu_restore_if #(
   parameter int K = 10,
   parameter int N = 32
);
   localparam int LOG2_K = $clog2(K);

   logic                  IsEmpty_Buffer;
   logic [N+LOG2_K-1:0]   PopVal_Buffer;
   logic                  PopEn_Buffer;
   logic                  Clr_Buffer;
   logic [K-1:0]          Restore_Ens_IC_Reg_Wrapper;
   logic [N-1:0]          Restore_Vin_IC_Reg_Wrapper;

   modport master (
      input  IsEmpty_Buffer,
      input  PopVal_Buffer,
      output PopEn_Buffer,
      output Clr_Buffer,
      output Restore_Ens_IC_Reg_Wrapper,
      output Restore_Vin_IC_Reg_Wrapper
   );

   modport slave (
      output IsEmpty_Buffer,
      output PopVal_Buffer,
      input  PopEn_Buffer,
      input  Clr_Buffer,
      input  Restore_Ens_IC_Reg_Wrapper,
      input  Restore_Vin_IC_Reg_Wrapper
   );
endinterface
`default_nettype wire

// File: rtl/pcu_restore_fsm.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module      : pcu_restore_fsm
// Description : Sequencer of the restore unit: state register, next-state
//               logic and state-decoded strobes/status.
// Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
module pcu_restore_fsm
   import pcu_restore_pkg::*;
(
   input  logic               Clk,
   input  logic               Rst,
   input  logic               i_abort,
   input  logic               i_start,
   input  logic               i_empty,
   output logic [STATE_W-1:0] o_state,
   output logic               o_pop_en,
   output logic               o_clr,
   output logic               o_busy,
   output logic               o_done
);

   logic [STATE_W-1:0] r_state;
   logic [STATE_W-1:0] w_next;

   // Next-state decode; power-off abandons the pass from any state
   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE:  if (i_start) w_next = i_empty ? ST_CLEAR : ST_POP;
         ST_POP:   w_next = ST_WRITE;
         ST_WRITE: w_next = i_empty ? ST_CLEAR : ST_POP;
         ST_CLEAR: w_next = ST_DONE;
         ST_DONE:  if (!i_start) w_next = ST_IDLE;
         default:  w_next = ST_IDLE;
      endcase
      if (i_abort) w_next = ST_IDLE;
   end

   // State register
   always_ff @(posedge Clk) begin
      if (Rst) r_state <= ST_IDLE;
      else     r_state <= w_next;
   end

   assign o_state  = r_state;
   // Pop is suppressed in the cycle an abort or reset arrives so the buffer
   // never advances past an entry that will not be written back
   assign o_pop_en = (r_state == ST_POP) && !i_empty && !i_abort && !Rst;
   assign o_clr    = (r_state == ST_CLEAR);
   assign o_busy   = (r_state == ST_POP) || (r_state == ST_WRITE) || (r_state == ST_CLEAR);
   assign o_done   = (r_state == ST_DONE);

endmodule
`default_nettype wire

// File: rtl/pcu_restore.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module      : pcu_restore
// Description : Power restore unit. Drains the backup buffer, decodes each
//               {value, wrapper address} entry and writes the value back into
//               the addressed IC register wrapper with a one-hot enable.
//               Optional macro PCU_RESTORE_ADDR_CHECK_EN: out-of-range
//               addresses are skipped, not counted, and flagged on Err.
// Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
module pcu_restore
   import pcu_restore_pkg::*;
#(
   parameter  int K      = 10,
   parameter  int N      = 32,
   parameter  int DEPTH  = 16,
   localparam int LOG2_K = $clog2(K),
   localparam int C      = $clog2(DEPTH + 1)
)(
   input  logic           Clk,
   input  logic           Rst,
   input  logic           Pwr_off,
   input  logic           Start_Restore,
   pcu_restore_if.master  bus,
   output logic           Busy,
   output logic           Done,
   output logic           Err,
   output logic [C-1:0]   Restored_Cnt
);

   localparam int           c_data_lsb = data_lsb(LOG2_K);
   localparam logic [C-1:0] c_cnt_max  = C'(DEPTH);
   localparam logic [K-1:0] c_one      = K'(1);

   logic [STATE_W-1:0] w_state;
   logic               w_pop_en;
   logic               w_start_pass;
   logic               w_cnt_inc;
   logic [LOG2_K-1:0]  w_entry_addr;
   logic [N-1:0]       w_entry_data;
   logic [K-1:0]       w_entry_dec;

   logic [N-1:0]       r_hold_data;
   logic [K-1:0]       r_ens;
   logic [C-1:0]       r_cnt;

   pcu_restore_fsm u_fsm (
      .Clk      (Clk),
      .Rst      (Rst),
      .i_abort  (Pwr_off),
      .i_start  (Start_Restore),
      .i_empty  (bus.IsEmpty_Buffer),
      .o_state  (w_state),
      .o_pop_en (w_pop_en),
      .o_clr    (bus.Clr_Buffer),
      .o_busy   (Busy),
      .o_done   (Done)
   );

   assign w_entry_addr = bus.PopVal_Buffer[ADDR_LSB +: LOG2_K];
   assign w_entry_data = bus.PopVal_Buffer[c_data_lsb +: N];
   assign w_start_pass = (w_state == ST_IDLE) && Start_Restore;

`ifdef PCU_RESTORE_ADDR_CHECK_EN
   logic [LOG2_K-1:0] r_hold_addr;
   logic              r_err;
   logic              w_entry_oor;
   logic              w_hold_oor;

   assign w_entry_oor = ({1'b0, w_entry_addr} >= (LOG2_K + 1)'(K));
   assign w_hold_oor  = ({1'b0, r_hold_addr}  >= (LOG2_K + 1)'(K));
   assign w_entry_dec = w_entry_oor ? '0 : (c_one << w_entry_addr);
   assign w_cnt_inc   = (w_state == ST_WRITE) && !w_hold_oor;

   // Held address and sticky range error, cleared at the start of each pass
   always_ff @(posedge Clk) begin
      if (Rst || Pwr_off) begin
         r_hold_addr <= '0;
         r_err       <= 1'b0;
      end else begin
         if (w_pop_en) r_hold_addr <= w_entry_addr;
         if (w_start_pass)                       r_err <= 1'b0;
         else if (w_state == ST_WRITE && w_hold_oor) r_err <= 1'b1;
      end
   end

   assign Err = r_err;
`else
   // Out-of-range addresses shift out of the K-bit field and give no enable
   assign w_entry_dec = c_one << w_entry_addr;
   assign w_cnt_inc   = (w_state == ST_WRITE);
   assign Err         = 1'b0;
`endif

   // Hold data and registered one-hot enable; the enable register carries the
   // decoded address so data and enable leave aligned in the WRITE cycle
   always_ff @(posedge Clk) begin
      if (Rst || Pwr_off) begin
         r_hold_data <= '0;
         r_ens       <= '0;
         r_cnt       <= '0;
      end else begin
         r_ens <= w_pop_en ? w_entry_dec : '0;
         if (w_pop_en) r_hold_data <= w_entry_data;
         if (w_start_pass)                        r_cnt <= '0;
         else if (w_cnt_inc && r_cnt != c_cnt_max) r_cnt <= r_cnt + C'(1);
      end
   end

   assign bus.PopEn_Buffer               = w_pop_en;
   assign bus.Restore_Ens_IC_Reg_Wrapper = r_ens;
   assign bus.Restore_Vin_IC_Reg_Wrapper = r_hold_data;
   assign Restored_Cnt                   = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pcu_restore.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module      : tb_pcu_restore
// Description : Self-checking bench for pcu_restore with a queue model of the
//               backup buffer and a cycle-indexed reference of a pass.
// Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
module tb_pcu_restore;
   import pcu_restore_pkg::*;

   localparam int K      = 10;
   localparam int N      = 32;
   localparam int DEPTH  = 16;
   localparam int LOG2_K = 4;
   localparam int C      = 5;
`ifdef PCU_RESTORE_ADDR_CHECK_EN
   localparam bit ADDR_CHK = 1'b1;
`else
   localparam bit ADDR_CHK = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         pwr_off = 1'b0;
   logic         start = 1'b0;
   logic         busy, done, err;
   logic [C-1:0] cnt;

   always #5 clk = ~clk;

   pcu_restore_if #(.K(K), .N(N)) bus ();

   pcu_restore #(.K(K), .N(N), .DEPTH(DEPTH)) dut (
      .Clk           (clk),
      .Rst           (rst),
      .Pwr_off       (pwr_off),
      .Start_Restore (start),
      .bus           (bus),
      .Busy          (busy),
      .Done          (done),
      .Err           (err),
      .Restored_Cnt  (cnt)
   );

   // Backup buffer model: first-word-fall-through queue
   logic [N+LOG2_K-1:0] q[$];
   logic pop_s = 1'b0;
   logic clr_s = 1'b0;

   function automatic void buf_update();
      bus.IsEmpty_Buffer = (q.size() == 0);
      bus.PopVal_Buffer  = (q.size() > 0) ? q[0] : '0;
   endfunction

   always @(negedge clk) begin
      pop_s = bus.PopEn_Buffer;
      clr_s = bus.Clr_Buffer;
   end

   always begin
      @(posedge clk);
      #1;
      if (pop_s && q.size() > 0) void'(q.pop_front());
      if (clr_s) q.delete();
      buf_update();
   end

   int n_chk  = 0;
   int n_pass = 0;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
   endtask

   // Entries of the next pass
   logic [N-1:0]      e_data[DEPTH];
   logic [LOG2_K-1:0] e_addr[DEPTH];
   int                e_n;

   task automatic check_idle(input string name, input int exp_cnt);
      check({name, " ens"},  bus.Restore_Ens_IC_Reg_Wrapper, '0);
      check({name, " vin"},  bus.Restore_Vin_IC_Reg_Wrapper, '0);
      check({name, " pop"},  bus.PopEn_Buffer, 0);
      check({name, " clr"},  bus.Clr_Buffer, 0);
      check({name, " busy"}, busy, 0);
      check({name, " done"}, done, 0);
      check({name, " err"},  err, 0);
      check({name, " cnt"},  cnt, exp_cnt);
   endtask

   // One full pass, called between edges with Start low; ends after Start
   // has been low for exactly one sampling edge
   task automatic run_pass(input string name);
      int clr_c, wr_cnt, idx;
      logic exp_err, exp_wr;
      logic [K-1:0] one, exp_ens;
      one = 1;
      wr_cnt = 0;
      q.delete();
      for (int i = 0; i < e_n; i++) q.push_back({e_data[i], e_addr[i]});
      buf_update();
      start = 1'b1;
      clr_c = (e_n == 0) ? 1 : 2 * e_n + 1;
      for (int c = 1; c <= clr_c + 3; c++) begin
         @(posedge clk);
         @(negedge clk);
         wr_cnt = 0;
         exp_err = 1'b0;
         for (int i = 0; i < e_n; i++) begin
            if (2 * i + 2 < c) begin
               if (ADDR_CHK && int'(e_addr[i]) >= K) exp_err = 1'b1;
               else wr_cnt++;
            end
         end
         if (wr_cnt > DEPTH) wr_cnt = DEPTH;
         exp_wr  = (c <= 2 * e_n) && (c % 2 == 0);
         idx     = exp_wr ? (c - 2) / 2 : 0;
         exp_ens = (exp_wr && int'(e_addr[idx]) < K) ? (one << e_addr[idx]) : '0;
         check($sformatf("%s c%0d pop", name, c), bus.PopEn_Buffer,
               (c <= 2 * e_n) && (c % 2 == 1));
         check($sformatf("%s c%0d ens", name, c), bus.Restore_Ens_IC_Reg_Wrapper, exp_ens);
         if (exp_wr)
            check($sformatf("%s c%0d vin", name, c), bus.Restore_Vin_IC_Reg_Wrapper, e_data[idx]);
         check($sformatf("%s c%0d clr", name, c),  bus.Clr_Buffer, c == clr_c);
         check($sformatf("%s c%0d busy", name, c), busy, c <= clr_c);
         check($sformatf("%s c%0d done", name, c), done, c > clr_c);
         check($sformatf("%s c%0d cnt", name, c),  cnt, wr_cnt);
         check($sformatf("%s c%0d err", name, c),  err, exp_err);
      end
      check({name, " drained"}, q.size(), 0);
      start = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check({name, " done drop"}, done, 0);
      check({name, " idle busy"}, busy, 0);
      check({name, " cnt hold"},  cnt, wr_cnt);
   endtask

   initial begin
      q.delete();
      buf_update();
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_idle("reset", 0);
      rst = 1'b0;
      @(negedge clk);

      // Empty buffer
      e_n = 0;
      run_pass("empty");

      // Three directed entries
      e_n = 3;
      e_data[0] = 32'hDEADBEEF; e_addr[0] = 4'd3;
      e_data[1] = 32'h12345678; e_addr[1] = 4'd0;
      e_data[2] = 32'hA5A5A5A5; e_addr[2] = 4'd9;
      run_pass("three");

      // Out-of-range address followed by a valid one
      e_n = 2;
      e_data[0] = 32'hCAFEF00D; e_addr[0] = 4'd12;
      e_data[1] = 32'h00000001; e_addr[1] = 4'd2;
      run_pass("oor");

      // Randomized passes, including duplicate and out-of-range addresses
      for (int p = 0; p < 8; p++) begin
         e_n = $urandom_range(0, DEPTH);
         for (int i = 0; i < e_n; i++) begin
            e_data[i] = $urandom;
            e_addr[i] = LOG2_K'($urandom_range(0, 15));
         end
         run_pass($sformatf("rnd%0d", p));
      end

      // Power-off abort during the second POP of a 3-entry pass
      q.delete();
      q.push_back({32'h11111111, 4'd1});
      q.push_back({32'h22222222, 4'd2});
      q.push_back({32'h33333333, 4'd3});
      buf_update();
      start = 1'b1;
      @(posedge clk); @(negedge clk);
      check("abort c1 pop", bus.PopEn_Buffer, 1);
      @(posedge clk); @(negedge clk);
      check("abort c2 ens", bus.Restore_Ens_IC_Reg_Wrapper, 10'h002);
      @(posedge clk); #1 pwr_off = 1'b1;
      @(negedge clk);
      check("abort c3 cnt", cnt, 1);
      @(posedge clk); #1 begin pwr_off = 1'b0; start = 1'b0; end
      for (int c = 4; c < 8; c++) begin
         @(negedge clk);
         check_idle($sformatf("abort c%0d", c), 0);
         @(posedge clk);
      end
      @(negedge clk);
      check("abort no pop", q.size(), 2);
      q.delete();
      buf_update();

      // Reset in the middle of a WRITE
      q.push_back({32'h44444444, 4'd4});
      q.push_back({32'h55555555, 4'd5});
      q.push_back({32'h66666666, 4'd6});
      buf_update();
      start = 1'b1;
      @(posedge clk); @(negedge clk);
      @(posedge clk); @(negedge clk);
      check("rstw c2 ens", bus.Restore_Ens_IC_Reg_Wrapper, 10'h010);
      check("rstw c2 vin", bus.Restore_Vin_IC_Reg_Wrapper, 32'h44444444);
      rst = 1'b1;
      @(posedge clk); @(negedge clk);
      check_idle("rstw c3", 0);
      rst = 1'b0;
      start = 1'b0;
      @(posedge clk); @(negedge clk);
      check_idle("rstw c4", 0);
      check("rstw no pop", q.size(), 2);
      q.delete();
      buf_update();

      // Recovery pass after the interruptions
      e_n = 4;
      for (int i = 0; i < e_n; i++) begin
         e_data[i] = $urandom;
         e_addr[i] = LOG2_K'($urandom_range(0, K - 1));
      end
      run_pass("recover");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
